tybec_map_node_elastic: RTL and testbench

Parametrised elastic leaf map node for TyBEC-generated kernel pipelines. It joins NIN input streams and optionally a compile-time constant operand, then applies one integer operation through a free-running LAT-stage pipeline. Results land in an output FIFO sized to cover every in-flight item, so downstream back-pressure never stalls the datapath. `iready` depends only on internal occupancy, never combinationally on `oready`. Sits between upstream stream producers and downstream map/reduce nodes, as a drop-in successor to the fixed-latency single-input leaf nodes.

---
 rtl/tybec_map_pkg.sv | 30 +++
 rtl/tybec_map_node_elastic_if.sv | 26 ++
 rtl/tybec_sync_fifo.sv | 78 +++++++
 rtl/tybec_map_node_elastic.sv | 141 ++++++++++++++
 tb/tb_tybec_map_node_elastic.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/tybec_map_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tybec_map_pkg
// Description : Shared operation encodings, default width and clog2 helper
//               for the TyBEC elastic map node.
// Revision    : 1.0 - initial release
// ============================================================================
package tybec_map_pkg;

    localparam logic [1:0] OP_ADD  = 2'd0;
    localparam logic [1:0] OP_MUL  = 2'd1;
    localparam logic [1:0] OP_MAX  = 2'd2;
    localparam logic [1:0] OP_PASS = 2'd3;

    localparam int DEFAULT_STREAMW = 34;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tybec_map_node_elastic_if.sv
`default_nettype none
// ============================================================================
// Module      : tybec_map_node_elastic_if
// Description : Joined-input / single-output stream bundle for the map node.
// Revision    : 1.0 - initial release
// ============================================================================
interface tybec_map_node_elastic_if
    import tybec_map_pkg::*;
#(
    parameter int STREAMW = DEFAULT_STREAMW,
    parameter int NIN     = 2
);

    logic [NIN-1:0]         ivalid;
    logic [NIN*STREAMW-1:0] in_data;
    logic                   iready;
    logic [STREAMW-1:0]     out1;
    logic                   ovalid;
    logic                   oready;

    // slave: the map node itself; master: the surrounding producer/consumer.
    modport slave  (input  ivalid, in_data, oready, output iready, out1, ovalid);
    modport master (output ivalid, in_data, oready, input  iready, out1, ovalid);

endinterface
`default_nettype wire

// File: rtl/tybec_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tybec_sync_fifo
// Description : Single-clock FIFO, arbitrary depth, registered storage with
//               no fall-through; head word is presented on rdata.
// Revision    : 1.0 - initial release
// ============================================================================
module tybec_sync_fifo
    import tybec_map_pkg::*;
#(
    parameter int  WIDTH = DEFAULT_STREAMW,
    parameter int  DEPTH = 4,
    localparam int PTRW  = (DEPTH > 1) ? clog2(DEPTH) : 1,
    localparam int CNTW  = clog2(DEPTH + 1)
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             push,
    input  wire logic             pop,
    input  wire logic [WIDTH-1:0] wdata,
    output logic      [WIDTH-1:0] rdata,
    output logic                  full,
    output logic                  empty,
    output logic      [CNTW-1:0]  count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]  count_q,  count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNTW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PTRW'(DEPTH - 1)) ? '0 : wr_ptr_q + PTRW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTRW'(DEPTH - 1)) ? '0 : rd_ptr_q + PTRW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tybec_map_node_elastic.sv
`default_nettype none
// ============================================================================
// Module      : tybec_map_node_elastic
// Description : Elastic leaf map node: joins NIN streams (plus an optional
//               constant), applies one integer op through a LAT-stage
//               free-running pipeline and buffers results in an output FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module tybec_map_node_elastic
    import tybec_map_pkg::*;
#(
    parameter int               STREAMW   = DEFAULT_STREAMW,
    parameter int               NIN       = 2,
    parameter int               LAT       = 13,
    parameter logic [1:0]       OP        = OP_ADD,
    parameter bit               CONST_EN  = 1'b1,
    parameter logic [STREAMW-1:0] CONST_VAL = STREAMW'(34'h1_3f802058),
    parameter int               FD        = LAT + 2,
    localparam int              OCCW      = clog2(FD + 1)
) (
    input  wire logic               clk,
    input  wire logic               rst,
    tybec_map_node_elastic_if.slave bus,
    output logic [OCCW-1:0]         occupancy
);

    logic [STREAMW-1:0] opnd [NIN];
    logic [STREAMW-1:0] result;
    logic               iready;
    logic               fire;
    logic               pop;
    logic               fifo_empty;
    logic               fifo_full;
    logic [OCCW-1:0]    fifo_count;

    logic [STREAMW-1:0] data_q  [LAT];
    logic [STREAMW-1:0] data_d  [LAT];
    logic [LAT-1:0]     valid_q, valid_d;
    logic [OCCW-1:0]    occ_q,   occ_d;

    // Gating with rst keeps iready low for the whole reset window.
    assign iready     = rst & (occ_q < OCCW'(FD));
    assign fire       = (&bus.ivalid) & iready;
    assign pop        = ~fifo_empty & bus.oready;
    assign bus.iready = iready;
    assign bus.ovalid = ~fifo_empty;
    assign occupancy  = occ_q;

    generate
        for (genvar k = 0; k < NIN; k++) begin : g_opnd
            assign opnd[k] = bus.in_data[k*STREAMW +: STREAMW];
        end
    endgenerate

    always_comb begin
        result = opnd[0];
        case (OP)
            OP_ADD: begin
                for (int k = 1; k < NIN; k++) begin
                    result = result + opnd[k];
                end
                if (CONST_EN) begin
                    result = result + CONST_VAL;
                end
            end
            OP_MUL: begin
                for (int k = 1; k < NIN; k++) begin
                    result = STREAMW'(result * opnd[k]);
                end
                if (CONST_EN) begin
                    result = STREAMW'(result * CONST_VAL);
                end
            end
            OP_MAX: begin
                for (int k = 1; k < NIN; k++) begin
                    if (opnd[k] > result) begin
                        result = opnd[k];
                    end
                end
                if (CONST_EN && (CONST_VAL > result)) begin
                    result = CONST_VAL;
                end
            end
            default: result = opnd[0];
        endcase
    end

    // Stage 0 samples the operator every cycle; only the valid bit matters.
    always_comb begin
        valid_d[0] = fire;
        data_d[0]  = result;
        for (int s = 1; s < LAT; s++) begin
            valid_d[s] = valid_q[s-1];
            data_d[s]  = data_q[s-1];
        end
    end

    always_comb begin
        occ_d = occ_q;
        case ({fire, pop})
            2'b10:   occ_d = occ_q + OCCW'(1);
            2'b01:   occ_d = occ_q - OCCW'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            occ_q   <= '0;
        end else begin
            valid_q <= valid_d;
            occ_q   <= occ_d;
        end
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    tybec_sync_fifo #(
        .WIDTH (STREAMW),
        .DEPTH (FD)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (valid_q[LAT-1]),
        .pop   (pop),
        .wdata (data_q[LAT-1]),
        .rdata (bus.out1),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // occ_q already bounds the FIFO; its own status flags are not needed here.
    logic unused_fifo_status;
    assign unused_fifo_status = &{1'b0, fifo_full, fifo_count};

endmodule
`default_nettype wire

// File: tb/tb_tybec_map_node_elastic.sv
`default_nettype none
// ============================================================================
// Module      : tb_tybec_map_node_elastic
// Description : Self-checking bench for the elastic map node (default build
//               plus four small 8-bit operator builds).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tybec_map_node_elastic;
    import tybec_map_pkg::*;

    localparam int          c_LAT = 13;
    localparam int          c_FD  = 15;
    localparam logic [33:0] c_K   = 34'h1_3f802058;
    localparam int          c_SLAT = 2;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Main build, default parameters.
    tybec_map_node_elastic_if #(.STREAMW(34), .NIN(2)) bm ();
    logic [3:0] occ_m;

    tybec_map_node_elastic u_dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bm),
        .occupancy (occ_m)
    );

    // Small 8-bit builds, one per operator, fed from a shared stimulus.
    logic [1:0]  s_valid;
    logic [15:0] s_data;
    logic [2:0]  occ_add, occ_mul, occ_max, occ_pass;

    tybec_map_node_elastic_if #(.STREAMW(8), .NIN(2)) bs_add ();
    tybec_map_node_elastic_if #(.STREAMW(8), .NIN(2)) bs_mul ();
    tybec_map_node_elastic_if #(.STREAMW(8), .NIN(2)) bs_max ();
    tybec_map_node_elastic_if #(.STREAMW(8), .NIN(2)) bs_pass ();

    assign bs_add.ivalid  = s_valid;  assign bs_add.in_data  = s_data;  assign bs_add.oready  = 1'b1;
    assign bs_mul.ivalid  = s_valid;  assign bs_mul.in_data  = s_data;  assign bs_mul.oready  = 1'b1;
    assign bs_max.ivalid  = s_valid;  assign bs_max.in_data  = s_data;  assign bs_max.oready  = 1'b1;
    assign bs_pass.ivalid = s_valid;  assign bs_pass.in_data = s_data;  assign bs_pass.oready = 1'b1;

    tybec_map_node_elastic #(.STREAMW(8), .NIN(2), .LAT(c_SLAT), .OP(OP_ADD),
                             .CONST_EN(1'b0), .CONST_VAL(8'h00))
        u_add  (.clk(clk), .rst(rst), .bus(bs_add),  .occupancy(occ_add));
    tybec_map_node_elastic #(.STREAMW(8), .NIN(2), .LAT(c_SLAT), .OP(OP_MUL),
                             .CONST_EN(1'b0), .CONST_VAL(8'h00))
        u_mul  (.clk(clk), .rst(rst), .bus(bs_mul),  .occupancy(occ_mul));
    tybec_map_node_elastic #(.STREAMW(8), .NIN(2), .LAT(c_SLAT), .OP(OP_MAX),
                             .CONST_EN(1'b1), .CONST_VAL(8'h40))
        u_max  (.clk(clk), .rst(rst), .bus(bs_max),  .occupancy(occ_max));
    tybec_map_node_elastic #(.STREAMW(8), .NIN(2), .LAT(c_SLAT), .OP(OP_PASS),
                             .CONST_EN(1'b1), .CONST_VAL(8'hAA))
        u_pass (.clk(clk), .rst(rst), .bus(bs_pass), .occupancy(occ_pass));

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] e_add;
        logic [7:0] e_mul;
        logic [7:0] e_max;
        logic [7:0] e_pass;
    } vec_t;

    typedef struct {
        logic [33:0] d;
        int          t;
    } item_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
        end
    endtask

    // Reference: two operands plus the constant, wrapped to 34 bits.
    function automatic logic [33:0] ref_add(input logic [33:0] a, input logic [33:0] b);
        logic [35:0] s;
        s = {2'b00, a} + {2'b00, b} + {2'b00, c_K};
        return s[33:0];
    endfunction

    // Caller is at the falling edge just after the accepting edge, inputs idle.
    task automatic await_out(input string name, input logic [33:0] exp);
        int lat;
        lat = 0;
        while (!bm.ovalid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_lat"}, 64'(lat), 64'(c_LAT));
        check({name, "_data"}, 64'(bm.out1), 64'(exp));
    endtask

    task automatic send_one(input string name, input logic [33:0] a, input logic [33:0] b);
        bm.in_data = {b, a};
        bm.ivalid  = 2'b11;
        @(negedge clk);
        bm.ivalid  = 2'b00;
        check({name, "_occ"}, 64'(occ_m), 64'd1);
        await_out(name, ref_add(a, b));
    endtask

    vec_t        vt [6];
    logic [33:0] bq [$];
    item_t       sq [$];

    initial begin
        int          acc;
        int          sent;
        int          cyc;
        int          sz;
        logic        exp_ov;
        logic        orr;
        logic [1:0]  v;
        logic [63:0] rr;
        logic [33:0] a, b;

        total = 0;
        bad   = 0;
        rst   = 1'b0;
        bm.ivalid  = 2'b00;
        bm.in_data = '0;
        bm.oready  = 1'b1;
        s_valid    = 2'b00;
        s_data     = '0;

        //          a      b      add    mul    max    pass
        vt[0] = '{8'hF0, 8'h20, 8'h10, 8'h00, 8'hF0, 8'hF0};
        vt[1] = '{8'h10, 8'h11, 8'h21, 8'h10, 8'h40, 8'h10};
        vt[2] = '{8'h03, 8'h05, 8'h08, 8'h0F, 8'h40, 8'h03};
        vt[3] = '{8'hFF, 8'hFF, 8'hFE, 8'h01, 8'hFF, 8'hFF};
        vt[4] = '{8'h00, 8'h41, 8'h41, 8'h00, 8'h41, 8'h00};
        vt[5] = '{8'h7F, 8'h02, 8'h81, 8'hFE, 8'h7F, 8'h7F};

        repeat (3) @(negedge clk);
        check("rst_iready", 64'(bm.iready), 64'd0);
        check("rst_ovalid", 64'(bm.ovalid), 64'd0);
        check("rst_occ", 64'(occ_m), 64'd0);
        rst = 1'b1;
        #1;
        check("post_rst_iready", 64'(bm.iready), 64'd1);
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            s_data  = {vt[i].b, vt[i].a};
            s_valid = 2'b11;
            @(negedge clk);
            s_valid = 2'b00;
            repeat (c_SLAT) @(negedge clk);
            check("vec_ovalid", {60'd0, bs_add.ovalid, bs_mul.ovalid, bs_max.ovalid, bs_pass.ovalid}, 64'hF);
            check("vec_add", 64'(bs_add.out1), 64'(vt[i].e_add));
            check("vec_mul", 64'(bs_mul.out1), 64'(vt[i].e_mul));
            check("vec_max", 64'(bs_max.out1), 64'(vt[i].e_max));
            check("vec_pass", 64'(bs_pass.out1), 64'(vt[i].e_pass));
            check("vec_occ", {52'd0, occ_add, occ_mul, occ_max, occ_pass}, {52'd0, {4{3'd1}}});
        end

        send_one("lat_add", 34'd5, 34'd7);
        @(negedge clk);

        bm.in_data = {34'h3_3333_3333, 34'h11};
        bm.ivalid  = 2'b01;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("join_hold_occ", 64'(occ_m), 64'd0);
        end
        bm.in_data = {34'h22, 34'h11};
        bm.ivalid  = 2'b11;
        @(negedge clk);
        bm.ivalid  = 2'b00;
        check("join_fire_occ", 64'(occ_m), 64'd1);
        await_out("join", 34'h1_3f80208b);
        @(negedge clk);

        bm.oready = 1'b0;
        acc = 0;
        for (int i = 0; i < 30; i++) begin
            a = 34'(acc + 1);
            b = 34'((acc + 1) << 8);
            bm.in_data = {b, a};
            bm.ivalid  = 2'b11;
            if (bm.iready) begin
                bq.push_back(ref_add(a, b));
                acc++;
            end
            @(negedge clk);
        end
        bm.ivalid = 2'b00;
        check("bp_accepts", 64'(acc), 64'(c_FD));
        check("bp_iready", 64'(bm.iready), 64'd0);
        check("bp_occ", 64'(occ_m), 64'(c_FD));
        repeat (c_LAT + 1) @(negedge clk);
        bm.oready = 1'b1;
        check("bp_iready_pre", 64'(bm.iready), 64'd0);
        for (int i = 0; i < c_FD; i++) begin
            if (i == 1) check("bp_iready_back", 64'(bm.iready), 64'd1);
            check("bp_ovalid", 64'(bm.ovalid), 64'd1);
            check("bp_data", 64'(bm.out1), 64'(bq.pop_front()));
            @(negedge clk);
        end
        check("bp_drained", 64'(bm.ovalid), 64'd0);
        @(negedge clk);

        sent = 0;
        cyc  = 0;
        while ((sent < 1000 || sq.size() > 0) && cyc < 20000) begin
            sz     = sq.size();
            exp_ov = (sz > 0) && (cyc >= sq[0].t + c_LAT);
            check("st_occ", 64'(occ_m), 64'(sz));
            check("st_iready", 64'(bm.iready), 64'(sz < c_FD));
            check("st_ovalid", 64'(bm.ovalid), 64'(exp_ov));
            if (exp_ov && bm.ovalid) check("st_data", 64'(bm.out1), 64'(sq[0].d));
            orr = 1'($urandom_range(1, 0));
            bm.oready = orr;
            if (exp_ov && orr) void'(sq.pop_front());
            v = 2'b00;
            if (sent < 1000) begin
                v[0] = ($urandom_range(3, 0) != 0);
                v[1] = ($urandom_range(3, 0) != 0);
            end
            rr = {$urandom, $urandom};
            a  = rr[33:0];
            rr = {$urandom, $urandom};
            b  = rr[33:0];
            bm.ivalid  = v;
            bm.in_data = {b, a};
            if ((&v) && (sz < c_FD)) begin
                sq.push_back('{ref_add(a, b), cyc + 1});
                sent++;
            end
            @(negedge clk);
            cyc++;
        end
        bm.ivalid = 2'b00;
        check("st_complete", 64'((sent == 1000) && (sq.size() == 0)), 64'd1);
        bm.oready = 1'b1;
        repeat (2) @(negedge clk);

        bm.oready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bm.in_data = {34'(i * 3), 34'(i)};
            bm.ivalid  = 2'b11;
            @(negedge clk);
        end
        bm.ivalid = 2'b00;
        repeat (c_LAT + 1) @(negedge clk);
        check("mr_pre_ovalid", 64'(bm.ovalid), 64'd1);
        check("mr_pre_occ", 64'(occ_m), 64'd6);
        #2;
        rst = 1'b0;
        #1;
        check("mr_ovalid", 64'(bm.ovalid), 64'd0);
        check("mr_occ", 64'(occ_m), 64'd0);
        check("mr_iready", 64'(bm.iready), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mr_rel_iready", 64'(bm.iready), 64'd1);
        check("mr_rel_ovalid", 64'(bm.ovalid), 64'd0);
        bm.oready = 1'b1;
        send_one("mr_new", 34'h2_0000_0001, 34'h0_ABCD_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
